// File: rtl/game_tick_sched.sv
// Game-tick scheduler: divides vsync frame pulses into speed-dependent ticks,
// handshaked with the snake engine through tick_done, with a one-deep tick queue.
module game_tick_sched #(
   parameter int LEVELS      = 8,
   parameter int INIT_LEVEL  = 0,
   parameter int BASE_FRAMES = 16,
   parameter int STEP_FRAMES = 2,
   parameter int MIN_FRAMES  = 2,
   parameter int AUTO_EAT    = 4,
   parameter int CNT_W       = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_vsync_pulse,
   input  logic                      i_run,
   input  logic                      i_speed_up,
   input  logic                      i_speed_down,
   input  logic                      i_eat,
   input  logic                      i_tick_done,
   output logic                      o_tick,
   output logic                      o_busy,
   output logic                      o_overrun,
   output logic [$clog2(LEVELS)-1:0] o_level
);

   localparam int LVL_W    = $clog2(LEVELS);
   localparam int EAT_W    = (AUTO_EAT > 1) ? $clog2(AUTO_EAT) : 1;
   localparam int EAT_LAST = (AUTO_EAT > 0) ? AUTO_EAT - 1 : 0;

   typedef enum logic [1:0] {
      S_COUNT = 2'd0,
      S_FIRE  = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [EAT_W-1:0]   eat_q, eat_d;
   logic               up_prev_q, down_prev_q;
   logic               pend_q, pend_d;
   logic               tick_q, tick_d;
   logic               busy_q, busy_d;
   logic               ovr_q, ovr_d;

   logic [31:0]        dec_w, raw_w, period_w;
   logic               counted, due;
   logic               up_edge, down_edge, auto_up, up_any;

   // Period is built in 32-bit unsigned arithmetic and floored at zero before
   // the MIN_FRAMES clamp, so high levels cannot wrap to a huge period.
   always_comb begin
      dec_w    = 32'(level_q) * 32'(STEP_FRAMES);
      raw_w    = (dec_w < 32'(BASE_FRAMES)) ? (32'(BASE_FRAMES) - dec_w) : 32'd0;
      period_w = (raw_w > 32'(MIN_FRAMES)) ? raw_w : 32'(MIN_FRAMES);
   end

   assign counted = i_vsync_pulse & i_run;
   assign due     = counted & (32'(cnt_q) >= (period_w - 32'd1));

   always_comb begin
      cnt_d = cnt_q;
      if (counted) begin
         cnt_d = due ? '0 : cnt_q + CNT_W'(1);
      end
   end

   assign up_edge   = i_speed_up & ~up_prev_q;
   assign down_edge = i_speed_down & ~down_prev_q;
   assign auto_up   = (AUTO_EAT != 0) && i_eat && (eat_q == EAT_W'(EAT_LAST));
   assign up_any    = up_edge | auto_up;

   always_comb begin
      eat_d = eat_q;
      if (i_eat) begin
         eat_d = (auto_up || AUTO_EAT == 0) ? '0 : eat_q + EAT_W'(1);
      end
   end

   // Simultaneous up and down cancel; saturation is silent at both ends.
   always_comb begin
      level_d = level_q;
      if (up_any && !down_edge && level_q != LVL_W'(LEVELS - 1)) begin
         level_d = level_q + LVL_W'(1);
      end else if (down_edge && !up_any && level_q != '0) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      ovr_d   = 1'b0;
      case (state_q)
         S_COUNT: begin
            if (due) state_d = S_FIRE;
         end
         S_FIRE: begin
            state_d = S_WAIT;
            if (due) begin
               if (pend_q) ovr_d  = 1'b1;
               else        pend_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (i_tick_done) begin
               // A tick due in the same cycle as tick_done fires directly;
               // if one was already queued, the new one takes its queue slot.
               state_d = (pend_q || due) ? S_FIRE : S_COUNT;
               pend_d  = pend_q & due;
            end else if (due) begin
               if (pend_q) ovr_d  = 1'b1;
               else        pend_d = 1'b1;
            end
         end
         default: begin
            state_d = S_COUNT;
            pend_d  = 1'b0;
         end
      endcase
      tick_d = (state_d == S_FIRE);
      busy_d = (state_d == S_WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_COUNT;
         cnt_q       <= '0;
         level_q     <= LVL_W'(INIT_LEVEL);
         eat_q       <= '0;
         up_prev_q   <= 1'b0;
         down_prev_q <= 1'b0;
         pend_q      <= 1'b0;
         tick_q      <= 1'b0;
         busy_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         eat_q       <= eat_d;
         up_prev_q   <= i_speed_up;
         down_prev_q <= i_speed_down;
         pend_q      <= pend_d;
         tick_q      <= tick_d;
         busy_q      <= busy_d;
         ovr_q       <= ovr_d;
      end
   end

   assign o_tick    = tick_q;
   assign o_busy    = busy_q;
   assign o_overrun = ovr_q;
   assign o_level   = level_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Directed bench for game_tick_sched: a default instance plus one with
// MIN_FRAMES=4 and AUTO_EAT=0 driven by the same stimulus.
module tb_game_tick_sched;

   logic       clk = 1'b0;
   logic       rst, i_vsync_pulse, i_run, i_speed_up, i_speed_down, i_eat;
   logic       i_tick_done, b_tick_done;
   logic       o_tick, o_busy, o_overrun;
   logic [2:0] o_level;
   logic       b_tick, b_busy, b_overrun;
   logic [2:0] b_level;

   int n_asserts = 0;
   int n_fail    = 0;
   int acc_ticks, acc_ovr, acc_bticks;
   int f_ticks, f_busy, f_first, fb_ticks;

   always #5 clk = ~clk;

   game_tick_sched dut (
      .clk(clk), .rst(rst), .i_vsync_pulse(i_vsync_pulse), .i_run(i_run),
      .i_speed_up(i_speed_up), .i_speed_down(i_speed_down), .i_eat(i_eat),
      .i_tick_done(i_tick_done), .o_tick(o_tick), .o_busy(o_busy),
      .o_overrun(o_overrun), .o_level(o_level)
   );

   game_tick_sched #(.MIN_FRAMES(4), .AUTO_EAT(0)) dut_b (
      .clk(clk), .rst(rst), .i_vsync_pulse(i_vsync_pulse), .i_run(i_run),
      .i_speed_up(i_speed_up), .i_speed_down(i_speed_down), .i_eat(i_eat),
      .i_tick_done(b_tick_done), .o_tick(b_tick), .o_busy(b_busy),
      .o_overrun(b_overrun), .o_level(b_level)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_acc();
      acc_ticks = 0; acc_ovr = 0; acc_bticks = 0;
   endtask

   // Each frame is 20 clocks with vsync in the first; optionally answers each
   // tick with tick_done three clocks after it.
   task automatic frames(input int n, input bit give_done);
      int since, bsince;
      for (int f = 0; f < n; f++) begin
         f_ticks = 0; f_busy = 0; f_first = 0; fb_ticks = 0;
         since = -1; bsince = -1;
         i_vsync_pulse = 1'b1;
         for (int c = 0; c < 20; c++) begin
            step();
            i_vsync_pulse = 1'b0;
            i_tick_done   = 1'b0;
            b_tick_done   = 1'b0;
            if (o_tick) begin
               f_ticks++;
               if (c == 0) f_first = 1;
               since = 0;
            end else if (since >= 0) since++;
            if (b_tick) begin
               fb_ticks++;
               bsince = 0;
            end else if (bsince >= 0) bsince++;
            if (o_busy) f_busy++;
            if (o_overrun) acc_ovr++;
            if (give_done && since == 3) begin i_tick_done = 1'b1; since = -1; end
            if (give_done && bsince == 3) begin b_tick_done = 1'b1; bsince = -1; end
         end
         acc_ticks  += f_ticks;
         acc_bticks += fb_ticks;
      end
   endtask

   task automatic press(input bit up, input bit down, input int n);
      for (int k = 0; k < n; k++) begin
         i_speed_up = up; i_speed_down = down;
         step();
         i_speed_up = 1'b0; i_speed_down = 1'b0;
         step();
      end
   endtask

   task automatic eat(input bit with_down, input int n);
      for (int k = 0; k < n; k++) begin
         i_eat = 1'b1; i_speed_down = with_down;
         step();
         i_eat = 1'b0; i_speed_down = 1'b0;
         step();
      end
   endtask

   initial begin
      rst = 1'b1; i_vsync_pulse = 1'b0; i_run = 1'b0; i_speed_up = 1'b0;
      i_speed_down = 1'b0; i_eat = 1'b0; i_tick_done = 1'b0; b_tick_done = 1'b0;
      step(); step();
      check("rst_tick", int'(o_tick), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_overrun", int'(o_overrun), 0);
      check("rst_level", int'(o_level), 0);
      rst = 1'b0;
      i_run = 1'b1;

      // Level 0: one tick per 16 frames, one cycle after its vsync.
      clear_acc();
      frames(15, 1'b1);
      check("l0_no_tick_1_15", acc_ticks, 0);
      frames(1, 1'b1);
      check("l0_tick_16_width", f_ticks, 1);
      check("l0_tick_latency", f_first, 1);
      check("l0_busy_cycles", f_busy, 3);
      clear_acc();
      frames(16, 1'b1);
      check("l0_ticks_17_32", acc_ticks, 1);
      check("l0_tick_32_latency", f_first, 1);
      check("l0_b_ticks_17_32", acc_bticks, 1);

      // Up to level 7 and saturate there.
      press(1'b1, 1'b0, 7);
      check("level_up7", int'(o_level), 7);
      press(1'b1, 1'b0, 3);
      check("level_sat_hi", int'(o_level), 7);
      check("b_level_sat_hi", int'(b_level), 7);
      clear_acc();
      frames(8, 1'b1);
      check("l7_ticks_8frames_p2", acc_ticks, 4);
      check("l7_b_ticks_8frames_p4", acc_bticks, 2);

      // Withhold tick_done: tick at vsync 2, queue at 4, drop at 6.
      clear_acc();
      frames(6, 1'b0);
      check("ovr_ticks", acc_ticks, 1);
      check("ovr_pulses", acc_ovr, 1);
      check("ovr_busy", int'(o_busy), 1);
      i_tick_done = 1'b1; b_tick_done = 1'b1;
      step();
      i_tick_done = 1'b0; b_tick_done = 1'b0;
      check("pend_fire_tick", int'(o_tick), 1);
      check("pend_fire_no_ovr", int'(o_overrun), 0);
      step();
      check("pend_busy_again", int'(o_busy), 1);
      check("pend_tick_width", int'(o_tick), 0);
      i_tick_done = 1'b1;
      step();
      i_tick_done = 1'b0;
      check("pend_done_idle", int'(o_busy), 0);

      // Cancel of simultaneous edges, then down to 0 and saturate.
      press(1'b0, 1'b1, 1);
      check("level_down6", int'(o_level), 6);
      press(1'b1, 1'b1, 1);
      check("level_both_cancel", int'(o_level), 6);
      press(1'b0, 1'b1, 8);
      check("level_sat_lo", int'(o_level), 0);

      // Auto speed-up every 4 apples.
      eat(1'b0, 3);
      check("eat3_level", int'(o_level), 0);
      eat(1'b0, 1);
      check("eat4_level", int'(o_level), 1);
      eat(1'b0, 4);
      check("eat8_level", int'(o_level), 2);
      check("b_eat8_no_auto", int'(b_level), 0);
      eat(1'b0, 3);
      eat(1'b1, 1);
      check("eat_with_down", int'(o_level), 2);
      press(1'b0, 1'b1, 2);
      check("level_back0", int'(o_level), 0);

      // Pause mid-period: counter holds at 10, resumes 6 vsyncs before tick.
      clear_acc();
      frames(10, 1'b1);
      check("run_pre_pause", acc_ticks, 0);
      i_run = 1'b0;
      frames(10, 1'b1);
      check("paused_no_tick", acc_ticks, 0);
      check("paused_no_btick", acc_bticks, 0);
      i_run = 1'b1;
      frames(5, 1'b1);
      check("resume_5_no_tick", acc_ticks, 0);
      frames(1, 1'b1);
      check("resume_tick6", f_first, 1);
      check("resume_b_ticks", acc_bticks, 1);

      // Reset while busy with a queued tick.
      press(1'b1, 1'b0, 7);
      clear_acc();
      frames(4, 1'b0);
      check("prerst_busy", int'(o_busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_wait_busy", int'(o_busy), 0);
      check("rst_wait_tick", int'(o_tick), 0);
      check("rst_wait_level", int'(o_level), 0);
      clear_acc();
      frames(15, 1'b1);
      check("postrst_no_tick", acc_ticks, 0);
      frames(1, 1'b1);
      check("postrst_tick16", f_first, 1);
      check("postrst_ticks", acc_ticks, 1);
      check("postrst_ovr", acc_ovr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
